// File: rtl/pbox_branch_ctrl_if.sv
// pbox_branch_ctrl_if: bundles the control, branch and status signals of the
// context control unit.
//   slave  modport: the control unit (takes start/abort/stall/branch/predicate,
//                   drives the context address, enable and status)
//   master modport: the sequencing environment (context memory side, PBox, host)
// Clock and reset are not part of the bundle.
interface pbox_branch_ctrl_if #(
  parameter int unsigned CCNT_WIDTH = 8,
  parameter int unsigned CYC_WIDTH  = 16
) ();
  logic                  START_I;
  logic [CCNT_WIDTH-1:0] START_ADDR_I;
  logic                  ABORT_I;
  logic                  STALL_I;
  logic [1:0]            BR_KIND_I;
  logic                  BR_INV_I;
  logic [CCNT_WIDTH-1:0] BR_TARGET_I;
  logic                  PRED_I;
  logic [CCNT_WIDTH-1:0] CCNT_O;
  logic                  EN_O;
  logic                  BUSY_O;
  logic                  DONE_O;
  logic [CYC_WIDTH-1:0]  CYCLES_O;

  modport master (
    output START_I, START_ADDR_I, ABORT_I, STALL_I,
    output BR_KIND_I, BR_INV_I, BR_TARGET_I, PRED_I,
    input  CCNT_O, EN_O, BUSY_O, DONE_O, CYCLES_O
  );

  modport slave (
    input  START_I, START_ADDR_I, ABORT_I, STALL_I,
    input  BR_KIND_I, BR_INV_I, BR_TARGET_I, PRED_I,
    output CCNT_O, EN_O, BUSY_O, DONE_O, CYCLES_O
  );
endinterface

// File: rtl/pbox_branch_ctrl.sv
// pbox_branch_ctrl: steps the reconfigurable array through its context memory
// and resolves branches with the PBox predicate.
//   CLK_I  clock, rising edge
//   RST_I  asynchronous active-high reset
//   bus    slave side of pbox_branch_ctrl_if:
//          START_I/START_ADDR_I start a run from IDLE, ABORT_I returns to IDLE,
//          STALL_I freezes sequencing, BR_*/PRED_I describe the executing
//          context; CCNT_O context address, EN_O array/PBox enable
//          (combinational), BUSY_O in RUN, DONE_O one-cycle pulse after halt,
//          CYCLES_O saturating count of executed contexts.
module pbox_branch_ctrl #(
  parameter int unsigned CCNT_WIDTH = 8,
  parameter int unsigned CYC_WIDTH  = 16
) (
  input logic              CLK_I,
  input logic              RST_I,
  pbox_branch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [1:0] BrNext = 2'b00;
  localparam logic [1:0] BrJump = 2'b01;
  localparam logic [1:0] BrCond = 2'b10;
  localparam logic [1:0] BrHalt = 2'b11;

  state_e                state_q;
  logic [CCNT_WIDTH-1:0] ccnt_q;
  logic [CYC_WIDTH-1:0]  cycles_q;
  logic                  busy_q;
  logic                  done_q;

  logic [CCNT_WIDTH-1:0] ccnt_inc;
  logic [CYC_WIDTH-1:0]  cycles_inc;
  logic                  cond_taken;

  assign ccnt_inc   = ccnt_q + CCNT_WIDTH'(1);  // natural wrap at all-ones
  assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + CYC_WIDTH'(1);
  assign cond_taken = bus.PRED_I ^ bus.BR_INV_I;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q  <= StIdle;
      ccnt_q   <= '0;
      cycles_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // a simultaneous abort blocks the start
          if (bus.START_I && !bus.ABORT_I) begin
            state_q  <= StRun;
            busy_q   <= 1'b1;
            ccnt_q   <= bus.START_ADDR_I;
            cycles_q <= '0;
          end
        end
        StRun: begin
          if (bus.ABORT_I) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (!bus.STALL_I) begin
            cycles_q <= cycles_inc;
            case (bus.BR_KIND_I)
              BrNext: ccnt_q <= ccnt_inc;
              BrJump: ccnt_q <= bus.BR_TARGET_I;
              BrCond: ccnt_q <= cond_taken ? bus.BR_TARGET_I : ccnt_inc;
              BrHalt: begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
              default: ccnt_q <= ccnt_inc;
            endcase
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.EN_O     = (state_q == StRun) && !bus.STALL_I;
  assign bus.CCNT_O   = ccnt_q;
  assign bus.BUSY_O   = busy_q;
  assign bus.DONE_O   = done_q;
  assign bus.CYCLES_O = cycles_q;

endmodule

// File: tb/tb_pbox_branch_ctrl.sv
// Bench for pbox_branch_ctrl: directed vector table, async-reset sequence and
// randomized run against a behavioural model of the sequencing rules.
module tb_pbox_branch_ctrl;

  localparam int unsigned CW = 8;
  localparam int unsigned YW = 16;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;

  pbox_branch_ctrl_if #(.CCNT_WIDTH(CW), .CYC_WIDTH(YW)) bus ();

  pbox_branch_ctrl #(.CCNT_WIDTH(CW), .CYC_WIDTH(YW)) dut (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .bus   (bus)
  );

  always #5 CLK_I = ~CLK_I;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int start, addr, abort, stall, kind, inv, tgt, pred;
    int e_en, e_ccnt, e_busy, e_done, e_cyc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int st, int ad, int ab, int sl, int k, int iv, int tg, int pr,
                              int een, int ecc, int ebu, int edn, int ecy);
    vec_t v;
    v.start = st; v.addr = ad; v.abort = ab; v.stall = sl; v.kind = k; v.inv = iv;
    v.tgt = tg; v.pred = pr; v.e_en = een; v.e_ccnt = ecc; v.e_busy = ebu;
    v.e_done = edn; v.e_cyc = ecy;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(int st, int ad, int ab, int sl, int k, int iv, int tg, int pr);
    bus.START_I      = st[0];
    bus.START_ADDR_I = ad[CW-1:0];
    bus.ABORT_I      = ab[0];
    bus.STALL_I      = sl[0];
    bus.BR_KIND_I    = k[1:0];
    bus.BR_INV_I     = iv[0];
    bus.BR_TARGET_I  = tg[CW-1:0];
    bus.PRED_I       = pr[0];
  endtask

  // Called at posedge+1: drive, check EN_O, clock, check registered outputs.
  task automatic step_chk(string tag, vec_t v);
    drive(v.start, v.addr, v.abort, v.stall, v.kind, v.inv, v.tgt, v.pred);
    #1;
    chk({tag, " en"}, int'(bus.EN_O), v.e_en);
    @(posedge CLK_I);
    #1;
    chk({tag, " ccnt"}, int'(bus.CCNT_O), v.e_ccnt);
    chk({tag, " busy"}, int'(bus.BUSY_O), v.e_busy);
    chk({tag, " done"}, int'(bus.DONE_O), v.e_done);
    chk({tag, " cycles"}, int'(bus.CYCLES_O), v.e_cyc);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " ccnt"}, int'(bus.CCNT_O), 0);
    chk({tag, " en"}, int'(bus.EN_O), 0);
    chk({tag, " busy"}, int'(bus.BUSY_O), 0);
    chk({tag, " done"}, int'(bus.DONE_O), 0);
    chk({tag, " cycles"}, int'(bus.CYCLES_O), 0);
  endtask

  // Behavioural model state: 0 idle, 1 run, 2 done
  int m_st, m_ccnt, m_cyc, m_done;

  initial begin
    // kinds: 0 next, 1 jump, 2 cond, 3 halt
    //           st ad    ab sl k  iv tg    pr   en ccnt  bu dn cyc
    // linear run 0x10..0x13
    vq.push_back(mk(1, 'h10, 0, 0, 0, 0, 0,    0,   0, 'h10, 1, 0, 0));
    vq.push_back(mk(0, 0,    0, 0, 0, 0, 0,    0,   1, 'h11, 1, 0, 1));
    vq.push_back(mk(0, 0,    0, 0, 0, 0, 0,    0,   1, 'h12, 1, 0, 2));
    vq.push_back(mk(0, 0,    0, 0, 0, 0, 0,    0,   1, 'h13, 1, 0, 3));
    vq.push_back(mk(0, 0,    0, 0, 3, 0, 0,    0,   1, 'h13, 0, 1, 4));
    vq.push_back(mk(0, 0,    0, 0, 0, 0, 0,    0,   0, 'h13, 0, 0, 4));
    // conditional branch at 0x05
    vq.push_back(mk(1, 'h05, 0, 0, 0, 0, 0,    0,   0, 'h05, 1, 0, 0));
    vq.push_back(mk(0, 0,    0, 0, 2, 0, 'h20, 1,   1, 'h20, 1, 0, 1));
    vq.push_back(mk(0, 0,    0, 0, 1, 0, 'h05, 0,   1, 'h05, 1, 0, 2));
    vq.push_back(mk(0, 0,    0, 0, 2, 1, 'h20, 1,   1, 'h06, 1, 0, 3));
    // abort with halt: no DONE; then start+abort in idle refused
    vq.push_back(mk(0, 0,    1, 0, 3, 0, 0,    0,   1, 'h06, 0, 0, 3));
    vq.push_back(mk(1, 'hFF, 1, 0, 0, 0, 0,    0,   0, 'h06, 0, 0, 3));
    // wrap-around, jump, start ignored in RUN
    vq.push_back(mk(1, 'hFF, 0, 0, 0, 0, 0,    0,   0, 'hFF, 1, 0, 0));
    vq.push_back(mk(0, 0,    0, 0, 0, 0, 0,    0,   1, 'h00, 1, 0, 1));
    vq.push_back(mk(0, 0,    0, 0, 1, 0, 'h7A, 0,   1, 'h7A, 1, 0, 2));
    vq.push_back(mk(1, 'h33, 0, 0, 0, 0, 0,    0,   1, 'h7B, 1, 0, 3));
    // stall 3 cycles at 0x08 (branch inputs ignored while stalled)
    vq.push_back(mk(0, 0,    0, 0, 1, 0, 'h08, 0,   1, 'h08, 1, 0, 4));
    vq.push_back(mk(0, 0,    0, 1, 3, 0, 0,    0,   0, 'h08, 1, 0, 4));
    vq.push_back(mk(0, 0,    0, 1, 1, 0, 'h55, 1,   0, 'h08, 1, 0, 4));
    vq.push_back(mk(0, 0,    0, 1, 2, 0, 'h55, 1,   0, 'h08, 1, 0, 4));
    vq.push_back(mk(0, 0,    0, 0, 0, 0, 0,    0,   1, 'h09, 1, 0, 5));
    vq.push_back(mk(0, 0,    0, 0, 3, 0, 0,    0,   1, 'h09, 0, 1, 6));
    vq.push_back(mk(0, 0,    1, 0, 0, 0, 0,    0,   0, 'h09, 0, 0, 6));
    // self-loop until predicate drops, then abort
    vq.push_back(mk(1, 'h40, 0, 0, 0, 0, 0,    0,   0, 'h40, 1, 0, 0));
    vq.push_back(mk(0, 0,    0, 0, 2, 0, 'h40, 1,   1, 'h40, 1, 0, 1));
    vq.push_back(mk(0, 0,    0, 0, 2, 0, 'h40, 1,   1, 'h40, 1, 0, 2));
    vq.push_back(mk(0, 0,    0, 0, 2, 0, 'h40, 0,   1, 'h41, 1, 0, 3));
    vq.push_back(mk(0, 0,    1, 0, 0, 0, 0,    0,   1, 'h41, 0, 0, 3));

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    RST_I = 1'b0;
    @(posedge CLK_I);
    #1;
    chk_reset_vals("reset");

    foreach (vq[i]) step_chk($sformatf("vec%0d", i), vq[i]);

    // Async reset mid-run at 0x33
    step_chk("rst_start", mk(1, 'h33, 0, 0, 0, 0, 0, 0, 0, 'h33, 1, 0, 0));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    RST_I = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    #2;
    RST_I = 1'b0;
    @(posedge CLK_I);
    #1;
    step_chk("post_rst0", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step_chk("post_rst1", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1));

    // Randomized run against the model, from a fresh reset
    RST_I = 1'b1;
    #3;
    RST_I = 1'b0;
    @(posedge CLK_I);
    #1;
    m_st = 0; m_ccnt = 0; m_cyc = 0; m_done = 0;
    for (int c = 0; c < 400; c++) begin
      int st, ad, ab, sl, k, iv, tg, pr, r;
      st = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ad = int'($urandom_range(0, 255));
      ab = ($urandom_range(0, 29) == 0) ? 1 : 0;
      sl = ($urandom_range(0, 3) == 0) ? 1 : 0;
      r  = int'($urandom_range(0, 15));
      k  = (r == 0) ? 3 : (r < 4) ? 1 : (r < 8) ? 2 : 0;
      iv = int'($urandom_range(0, 1));
      tg = int'($urandom_range(0, 255));
      pr = int'($urandom_range(0, 1));
      drive(st, ad, ab, sl, k, iv, tg, pr);
      #1;
      chk($sformatf("rnd%0d en", c), int'(bus.EN_O), (m_st == 1 && sl == 0) ? 1 : 0);
      m_done = 0;
      if (m_st == 0) begin
        if (st == 1 && ab == 0) begin
          m_st = 1; m_ccnt = ad; m_cyc = 0;
        end
      end else if (m_st == 1) begin
        if (ab == 1) m_st = 0;
        else if (sl == 0) begin
          m_cyc = (m_cyc + 1 > 65535) ? 65535 : m_cyc + 1;
          if (k == 0) m_ccnt = (m_ccnt + 1) % 256;
          else if (k == 1) m_ccnt = tg;
          else if (k == 2) m_ccnt = (pr != iv) ? tg : (m_ccnt + 1) % 256;
          else begin
            m_st = 2; m_done = 1;
          end
        end
      end else begin
        m_st = 0;
      end
      @(posedge CLK_I);
      #1;
      chk($sformatf("rnd%0d ccnt", c), int'(bus.CCNT_O), m_ccnt);
      chk($sformatf("rnd%0d busy", c), int'(bus.BUSY_O), (m_st == 1) ? 1 : 0);
      chk($sformatf("rnd%0d done", c), int'(bus.DONE_O), m_done);
      chk($sformatf("rnd%0d cycles", c), int'(bus.CYCLES_O), m_cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pbox_branch_ctrl.md
# pbox_branch_ctrl

Context control unit that sequences the reconfigurable array through its context memory and resolves branches using the predicate produced by the PBox. It drives the context address and the array-wide enable, which also serves as the PBox `EN_I`. Each executed context carries a small branch-control field. The PBox combinational predicate, `Comb_O`, is fed back to select between fall-through and jump. The block sits directly downstream of the PBox and upstream of the context memories.

## Interface
Parameters:
- `CCNT_WIDTH`, 8: context address width. The context memory depth is 2^CCNT_WIDTH.
- `CYC_WIDTH`, 16: width of the executed-cycle counter.

Ports (one clock; reset is asynchronous and active-high):
- `CLK_I`  in  1  clock, rising edge.
- `RST_I`  in  1  asynchronous, active-high reset.
- `START_I`  in  1  start request. Accepted only in IDLE.
- `START_ADDR_I`  in  CCNT_WIDTH  first context address, sampled with an accepted start.
- `ABORT_I`  in  1  synchronous abort. Returns the block to IDLE without asserting `DONE_O`.
- `STALL_I`  in  1  array stall, e.g. a pending memory access. Freezes sequencing.
- `BR_KIND_I`  in  2  branch kind of the context at `CCNT_O`:
  - 00 = next
  - 01 = jump
  - 10 = conditional jump
  - 11 = halt
- `BR_INV_I`  in  1  inverts `PRED_I` for a conditional jump.
- `BR_TARGET_I`  in  CCNT_WIDTH  jump target.
- `PRED_I`  in  1  predicate, connected to PBox `Comb_O`.
- `CCNT_O`  out  CCNT_WIDTH  current context address.
- `EN_O`  out  1  array/PBox enable.
- `BUSY_O`  out  1  high in RUN.
- `DONE_O`  out  1  one-cycle pulse after a halt executes.
- `CYCLES_O`  out  CYC_WIDTH  number of executed contexts in the current run. Saturating.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `START_I`=1 → RUN; `CCNT_O` ← `START_ADDR_I`; `CYCLES_O` ← 0.
  - Otherwise remain in IDLE.
- **RUN**
  - `EN_O` = !`STALL_I`. This is combinational from the state register and `STALL_I`.
  - A context *executes* in a RUN cycle with `STALL_I`=0.
  - `BR_*` and `PRED_I` are valid, and sampled, only in executing cycles. They are ignored otherwise.
- **Next address in an executing cycle**
  - next: `CCNT_O`+1, wrapping modulo 2^CCNT_WIDTH (all-ones → 0).
  - jump: `BR_TARGET_I`.
  - conditional jump: if (`PRED_I` ^ `BR_INV_I`) then `BR_TARGET_I`, else `CCNT_O`+1 (same wrap).
  - halt: `CCNT_O` holds; state → DONE.
- **Cycle counter:** increments on every executing cycle, including the halt context. It saturates at all-ones.
- **Stall:** `CCNT_O`, state and `CYCLES_O` hold; `EN_O`=0.
- **DONE:** `DONE_O`=1, `EN_O`=0, `BUSY_O`=0; → IDLE next cycle. `CCNT_O` and `CYCLES_O` hold until the next accepted start.
- **Priority:** `ABORT_I` > halt > other branch kinds.
  - `ABORT_I`=1 in RUN or DONE → IDLE next cycle.
  - On abort, `CCNT_O` and `CYCLES_O` hold and `DONE_O` is not asserted.
  - `ABORT_I` in IDLE has no effect; it also blocks a simultaneous `START_I`.
- `START_I` in RUN or DONE is ignored.
- A jump to the current address, i.e. a self-loop, is legal. It repeats until `PRED_I` changes, or until abort.

## Timing
- **Reset values:** state IDLE; `CCNT_O`=0, `EN_O`=0, `BUSY_O`=0, `DONE_O`=0, `CYCLES_O`=0.
- Reset is asynchronous and takes effect immediately, including mid-run. No `DONE_O` is generated on reset.
- **Start latency:** `START_I` sampled at edge t → from t+1, `BUSY_O`=1, `EN_O`=!`STALL_I`, `CCNT_O`=`START_ADDR_I`.
- **Branch resolution:** a context executed in cycle n produces its next `CCNT_O` at edge n+1. There is one context per cycle with no bubbles, including on taken branches.
- **Halt:** a halt executed in cycle n gives, in cycle n+1, `EN_O`=0 and `DONE_O`=1. In cycle n+2 the block is in IDLE and a new start is accepted.
- `PRED_I` is combinational from the PBox. It must settle within the same cycle as `EN_O`.
- `DONE_O`, `BUSY_O`, `CCNT_O` and `CYCLES_O` are registered. `EN_O` is the only combinational output.

## Test plan
- **Linear run:** start at 0x10 with contexts 0x10–0x12 = next, and 0x13 = halt.
  - `CCNT_O` shows 0x10, 0x11, 0x12, 0x13 on consecutive cycles.
  - `DONE_O` pulses once, the cycle after 0x13 executes.
  - `CYCLES_O`=4.
- **Conditional branch:** context 0x05 = conditional jump, target 0x20.
  - `PRED_I`=1, `BR_INV_I`=0 → next `CCNT_O`=0x20.
  - `PRED_I`=1, `BR_INV_I`=1 → next `CCNT_O`=0x06.
- **Wrap-around and jump:** start at 0xFF with kind next → next `CCNT_O`=0x00. An unconditional jump to 0x7A is then taken in one cycle.
- **Stall:** assert `STALL_I` for 3 cycles mid-run at 0x08.
  - `EN_O`=0 throughout the stall.
  - `CCNT_O` stays 0x08 and `CYCLES_O` is unchanged.
  - Sequencing resumes with no skipped context.
- **Abort and priority:**
  - `ABORT_I` together with a halt → IDLE next cycle, no `DONE_O`.
  - `START_I` during RUN is ignored.
  - `START_I` together with `ABORT_I` in IDLE is not accepted.
- **Async reset mid-run:** assert `RST_I` between clock edges at `CCNT_O`=0x33 → all outputs go to reset values immediately. After release, a new start at 0x00 behaves normally.
